wait_state_ram: RTL and testbench

WAIT_STATE_RAM -- requirements
Module: wait_state_ram

---
 rtl/hc_bus_pkg.sv | 37 +++
 rtl/sync_ram_array.sv | 37 +++
 rtl/wait_state_ram.sv | 169 ++++++++++++++++
 tb/tb_wait_state_ram.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/hc_bus_pkg.sv
// Shared definitions for the handshake bus slaves: FSM state encodings,
// operation encoding, wait-state defaults and strobe decode helpers.
package hc_bus_pkg;

    // Access FSM states shared by all wait-state bus slaves
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        DONE = 2'd2
    } bus_state_t;

    // Latched bus operation
    typedef enum logic {
        OP_READ  = 1'b0,
        OP_WRITE = 1'b1
    } bus_op_t;

    localparam int DEFAULT_WAIT_STATES = 2;
    localparam int MAX_WAIT_STATES     = 15;
    localparam int WAIT_CNT_W          = 4;

    // Exactly one of the active-low strobes is asserted
    function automatic logic single_strobe(input logic n_rd, input logic n_wr);
        return n_rd ^ n_wr;
    endfunction

    // Both active-low strobes asserted together: a protocol violation
    function automatic logic both_strobes(input logic n_rd, input logic n_wr);
        return !n_rd && !n_wr;
    endfunction

    // Operation requested by a single asserted strobe
    function automatic bus_op_t strobe_op(input logic n_wr);
        return n_wr ? OP_READ : OP_WRITE;
    endfunction

endpackage

// File: rtl/sync_ram_array.sv
// Single-port-write / synchronous-read word array. Contents are never
// cleared; only the read data register returns to zero on reset.
module sync_ram_array #(
    parameter int ADDR_WIDTH = 16,
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wr_en,
    input  logic [ADDR_WIDTH-1:0] wr_addr,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  rd_en,
    input  logic [ADDR_WIDTH-1:0] rd_addr,
    output logic [DATA_WIDTH-1:0] rd_data
);

    localparam int DEPTH = 1 << ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] mem [0:DEPTH-1];

    // Write port: store one word when enabled
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    // Read port: registered data, held between reads, cleared by reset
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_data <= '0;
        end else if (rd_en) begin
            rd_data <= mem[rd_addr];
        end
    end

endmodule

// File: rtl/wait_state_ram.sv
// Wait-state RAM slave: a strobe-driven access FSM that inserts a fixed
// number of wait cycles before each access completes, with a memory-mapped
// output register shadowing one array location and a sticky protocol error.
module wait_state_ram
    import hc_bus_pkg::*;
#(
    parameter int                    ADDR_WIDTH  = 16,
    parameter int                    DATA_WIDTH  = 8,
    parameter int                    WAIT_STATES = DEFAULT_WAIT_STATES,
    parameter logic [ADDR_WIDTH-1:0] IO_ADDR     = '1
) (
    input  logic                  clk,
    input  logic                  Reset,
    input  logic [ADDR_WIDTH-1:0] address,
    input  logic [DATA_WIDTH-1:0] data_in,
    output logic [DATA_WIDTH-1:0] data_out,
    input  logic                  nRAM_RD,
    input  logic                  nRAM_WR,
    output logic                  nReady,
    output logic [DATA_WIDTH-1:0] io_out,
    output logic                  err
);

    // Counter start value; unused when no wait states are configured
    localparam logic [WAIT_CNT_W-1:0] WAIT_LOAD =
        (WAIT_STATES > 0) ? WAIT_CNT_W'(WAIT_STATES - 1) : '0;

    bus_state_t state;
    bus_state_t state_next;

    logic [WAIT_CNT_W-1:0] wait_cnt;

    logic [ADDR_WIDTH-1:0] addr_q;
    logic [DATA_WIDTH-1:0] data_q;
    bus_op_t               op_q;

    logic                  req_accept;
    logic                  strobe_released;
    logic                  exec;
    logic                  mem_wr;
    logic                  mem_rd;
    logic                  io_hit;
    logic [ADDR_WIDTH-1:0] acc_addr;
    logic [DATA_WIDTH-1:0] acc_data;
    bus_op_t               acc_op;

    // The strobe that owns the in-flight access has been released
    assign strobe_released = (op_q == OP_WRITE) ? nRAM_WR : nRAM_RD;

    // With zero wait states the access executes on the request edge itself,
    // so the live bus values are used; otherwise the latched copies are.
    assign acc_addr = (state == IDLE) ? address : addr_q;
    assign acc_data = (state == IDLE) ? data_in : data_q;
    assign acc_op   = (state == IDLE) ? strobe_op(nRAM_WR) : op_q;

    // State register
    always_ff @(posedge clk) begin
        if (Reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state decode
    always_comb begin
        state_next = state;
        unique case (state)
            IDLE: begin
                if (single_strobe(nRAM_RD, nRAM_WR)) begin
                    state_next = (WAIT_STATES > 0) ? WAIT : DONE;
                end
            end
            WAIT: begin
                if (strobe_released) begin
                    state_next = IDLE;
                end else if (wait_cnt == '0) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                if (nRAM_RD && nRAM_WR) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Output decode: handshake, request capture and one-shot execute on DONE entry
    always_comb begin
        nReady     = 1'b1;
        req_accept = 1'b0;
        exec       = 1'b0;
        unique case (state)
            IDLE: begin
                req_accept = single_strobe(nRAM_RD, nRAM_WR);
                exec       = req_accept && (state_next == DONE);
            end
            WAIT: begin
                exec = (state_next == DONE);
            end
            DONE: begin
                nReady = 1'b0;
            end
            default: begin
                nReady = 1'b1;
            end
        endcase
    end

    // A reset arriving on the execute edge suppresses the access
    assign mem_wr = exec && !Reset && (acc_op == OP_WRITE);
    assign mem_rd = exec && !Reset && (acc_op == OP_READ);
    assign io_hit = (acc_addr == IO_ADDR);

    // Request capture: address, data and operation frozen on the request edge
    always_ff @(posedge clk) begin
        if (req_accept) begin
            addr_q <= address;
            data_q <= data_in;
            op_q   <= strobe_op(nRAM_WR);
        end
    end

    // Wait-state counter: loaded on entry to WAIT, counts down to zero
    always_ff @(posedge clk) begin
        if (Reset) begin
            wait_cnt <= '0;
        end else if (state == IDLE && state_next == WAIT) begin
            wait_cnt <= WAIT_LOAD;
        end else if (state == WAIT && wait_cnt != '0) begin
            wait_cnt <= wait_cnt - 1'b1;
        end
    end

    // Sticky protocol error: both strobes asserted while idle
    always_ff @(posedge clk) begin
        if (Reset) begin
            err <= 1'b0;
        end else if (state == IDLE && both_strobes(nRAM_RD, nRAM_WR)) begin
            err <= 1'b1;
        end
    end

    // Memory-mapped output register mirrors writes to IO_ADDR
    always_ff @(posedge clk) begin
        if (Reset) begin
            io_out <= '0;
        end else if (mem_wr && io_hit) begin
            io_out <= acc_data;
        end
    end

    sync_ram_array #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .DATA_WIDTH (DATA_WIDTH)
    ) u_array (
        .clk     (clk),
        .rst     (Reset),
        .wr_en   (mem_wr),
        .wr_addr (acc_addr),
        .wr_data (acc_data),
        .rd_en   (mem_rd),
        .rd_addr (acc_addr),
        .rd_data (data_out)
    );

endmodule

// File: tb/tb_wait_state_ram.sv
// Directed bench for wait_state_ram: one instance with two wait states and
// one with none, sharing clock and reset.
module tb_wait_state_ram;

    logic        clk = 1'b0;
    logic        Reset;

    logic [15:0] address;
    logic [7:0]  data_in;
    logic [7:0]  data_out;
    logic        nRAM_RD;
    logic        nRAM_WR;
    logic        nReady;
    logic [7:0]  io_out;
    logic        err;

    logic [15:0] b_address;
    logic [7:0]  b_data_in;
    logic [7:0]  b_data_out;
    logic        b_nRD;
    logic        b_nWR;
    logic        b_nReady;
    logic [7:0]  b_io_out;
    logic        b_err;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    wait_state_ram #(
        .ADDR_WIDTH  (16),
        .DATA_WIDTH  (8),
        .WAIT_STATES (2)
    ) dut (
        .clk      (clk),
        .Reset    (Reset),
        .address  (address),
        .data_in  (data_in),
        .data_out (data_out),
        .nRAM_RD  (nRAM_RD),
        .nRAM_WR  (nRAM_WR),
        .nReady   (nReady),
        .io_out   (io_out),
        .err      (err)
    );

    wait_state_ram #(
        .ADDR_WIDTH  (16),
        .DATA_WIDTH  (8),
        .WAIT_STATES (0)
    ) dut0 (
        .clk      (clk),
        .Reset    (Reset),
        .address  (b_address),
        .data_in  (b_data_in),
        .data_out (b_data_out),
        .nRAM_RD  (b_nRD),
        .nRAM_WR  (b_nWR),
        .nReady   (b_nReady),
        .io_out   (b_io_out),
        .err      (b_err)
    );

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Full two-wait-state access; bus values are scrambled after the request edge
    task automatic a_access(input bit wr, input logic [15:0] a, input logic [7:0] d);
        address = a;
        data_in = d;
        if (wr) nRAM_WR = 1'b0;
        else    nRAM_RD = 1'b0;
        tick();
        check("wait1_nready", 32'(nReady), 32'h1);
        address = ~a;
        data_in = ~d;
        tick();
        check("wait2_nready", 32'(nReady), 32'h1);
        tick();
        check("done_nready", 32'(nReady), 32'h0);
        tick();
        check("hold_nready", 32'(nReady), 32'h0);
        nRAM_WR = 1'b1;
        nRAM_RD = 1'b1;
        tick();
        check("release_nready", 32'(nReady), 32'h1);
        tick();
        check("idle_nready", 32'(nReady), 32'h1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        Reset     = 1'b1;
        address   = 16'h0;
        data_in   = 8'h0;
        nRAM_RD   = 1'b1;
        nRAM_WR   = 1'b1;
        b_address = 16'h0;
        b_data_in = 8'h0;
        b_nRD     = 1'b1;
        b_nWR     = 1'b1;
        tick();
        tick();

        check("rst_nready", 32'(nReady), 32'h1);
        check("rst_data_out", 32'(data_out), 32'h0);
        check("rst_io_out", 32'(io_out), 32'h0);
        check("rst_err", 32'(err), 32'h0);
        check("rst_b_nready", 32'(b_nReady), 32'h1);
        Reset = 1'b0;
        tick();

        // Write then read back through the wait states
        a_access(1'b1, 16'h0010, 8'h5A);
        check("wr_keeps_data_out", 32'(data_out), 32'h0);
        a_access(1'b0, 16'h0010, 8'h00);
        check("rd_0010", 32'(data_out), 32'h5A);

        // Output register location
        a_access(1'b1, 16'hFFFF, 8'hC3);
        check("io_out_c3", 32'(io_out), 32'hC3);
        check("io_wr_keeps_data_out", 32'(data_out), 32'h5A);
        a_access(1'b0, 16'hFFFF, 8'h00);
        check("rd_ffff", 32'(data_out), 32'hC3);

        // Aborted write must leave the old contents in place
        a_access(1'b1, 16'h0020, 8'h11);
        address = 16'h0020;
        data_in = 8'h77;
        nRAM_WR = 1'b0;
        tick();
        nRAM_WR = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            check("abort_nready", 32'(nReady), 32'h1);
        end
        check("abort_data_out", 32'(data_out), 32'hC3);
        a_access(1'b0, 16'h0020, 8'h00);
        check("rd_after_abort", 32'(data_out), 32'h11);

        // Both strobes low while idle: sticky error, no access
        nRAM_RD = 1'b0;
        nRAM_WR = 1'b0;
        tick();
        check("err_set", 32'(err), 32'h1);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("err_no_access", 32'(nReady), 32'h1);
        end
        nRAM_RD = 1'b1;
        nRAM_WR = 1'b1;
        tick();
        tick();
        check("err_sticky", 32'(err), 32'h1);
        check("err_data_out", 32'(data_out), 32'h11);
        Reset = 1'b1;
        tick();
        Reset = 1'b0;
        check("err_cleared", 32'(err), 32'h0);
        check("rst2_data_out", 32'(data_out), 32'h0);
        check("rst2_io_out", 32'(io_out), 32'h0);

        // Array survives reset
        a_access(1'b0, 16'hFFFF, 8'h00);
        check("array_kept", 32'(data_out), 32'hC3);

        // Reset during WAIT aborts the write
        address = 16'h0010;
        data_in = 8'h99;
        nRAM_WR = 1'b0;
        tick();
        Reset = 1'b1;
        tick();
        Reset   = 1'b0;
        nRAM_WR = 1'b1;
        check("rst_wait_nready", 32'(nReady), 32'h1);
        tick();
        check("rst_wait_idle", 32'(nReady), 32'h1);
        a_access(1'b0, 16'h0010, 8'h00);
        check("rst_wait_no_write", 32'(data_out), 32'h5A);

        // Reset during DONE of an output-register write
        address = 16'hFFFF;
        data_in = 8'hA5;
        nRAM_WR = 1'b0;
        tick();
        tick();
        tick();
        check("io_done_nready", 32'(nReady), 32'h0);
        check("io_done_io_out", 32'(io_out), 32'hA5);
        Reset = 1'b1;
        tick();
        check("io_rst_io_out", 32'(io_out), 32'h0);
        check("io_rst_nready", 32'(nReady), 32'h1);
        Reset   = 1'b0;
        nRAM_WR = 1'b1;
        tick();
        check("io_rst_idle", 32'(nReady), 32'h1);
        a_access(1'b0, 16'h0010, 8'h00);
        check("post_rst_read", 32'(data_out), 32'h5A);

        // Zero wait states: completion on the request edge
        b_address = 16'h0040;
        b_data_in = 8'h3C;
        b_nWR     = 1'b0;
        tick();
        check("b_wr_nready", 32'(b_nReady), 32'h0);
        b_address = 16'h0041;
        b_data_in = 8'hFF;
        b_nWR     = 1'b1;
        tick();
        check("b_wr_release", 32'(b_nReady), 32'h1);
        b_address = 16'h0040;
        b_nRD     = 1'b0;
        tick();
        check("b_rd_nready", 32'(b_nReady), 32'h0);
        check("b_rd_data", 32'(b_data_out), 32'h3C);
        b_nRD = 1'b1;
        tick();
        check("b_rd_release", 32'(b_nReady), 32'h1);
        check("b_err", 32'(b_err), 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
